// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the VGA framebuffer arbiter.
package vga_fb_pkg;

  localparam int PIX_W    = 8;
  localparam int WORD_W   = 4 * PIX_W;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;
  localparam int ADDR_W   = 17;
  localparam int GPL      = H_ACTIVE / 4;
  localparam int FB_WORDS = V_ACTIVE * H_ACTIVE / 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/vga_fb_line_addr.sv
// Word address of (line, group): line*160 + group, built from two shifts and adds.
module vga_fb_line_addr
  import vga_fb_pkg::*;
(
  input  logic [9:0]        line,
  input  logic [7:0]        grp,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] line_w;

  // line*160 = line*128 + line*32; no overflow for any visible line
  always_comb begin
    line_w = ADDR_W'(line);
    addr   = (line_w << 7) + (line_w << 5) + ADDR_W'(grp);
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer RAM between VGA scan-out prefetch and one
// pixel writer. Reads own every read slot; a one-entry buffer retires writes
// in the remaining cycles.
module vga_fb_arbiter
  import vga_fb_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic                video_on,
  input  logic                hsync,
  input  logic                vsync,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [4*PIX_W-1:0]  wr_data,
  output logic                wr_err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [4*PIX_W-1:0]  mem_wdata,
  input  logic [4*PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]    pixel,
  output logic                video_on_q,
  output logic                hsync_q,
  output logic                vsync_q
);

  localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_WORDS);

  buf_state_e        state_q, state_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  word_t             buf_data_q, buf_data_d;
  logic              wr_err_q, wr_err_d;
  logic              rd_q, rd_d;
  word_t             next_word_q, next_word_d;
  word_t             cur_word_q, cur_word_d;
  logic [PIX_W-1:0]  pixel_q, pixel_d;
  logic              video_on_d, hsync_d, vsync_d;

  logic [1:0]        phase;
  logic [7:0]        grp;
  logic [8:0]        grp_nxt;
  logic [9:0]        nl;
  logic              inline_rd, ls_slot, rd_slot, buf_in_range;
  logic [9:0]        line_sel;
  logic [7:0]        grp_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  lane;

  // Read-slot decode: in-line prefetch of the next group, or next-line start
  always_comb begin
    phase     = x[1:0];
    grp       = x[9:2];
    grp_nxt   = {1'b0, grp} + 9'd1;
    inline_rd = (phase == 2'd0) && (grp_nxt < 9'(GPL)) && (y < 10'(V_ACTIVE));
    ls_slot   = (x == 10'(H_TOTAL - 4));
    nl        = (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
    rd_slot   = inline_rd || (ls_slot && (nl < 10'(V_ACTIVE)));
    line_sel  = ls_slot ? nl : y;
    grp_sel   = ls_slot ? 8'd0 : grp_nxt[7:0];
  end

  vga_fb_line_addr u_line_addr (
    .line (line_sel),
    .grp  (grp_sel),
    .addr (rd_addr)
  );

  // RAM port arbitration and write-buffer next state
  always_comb begin
    state_d      = state_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    wr_err_d     = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    buf_in_range = (buf_addr_q < FB_LIMIT);
    if (rd_slot) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr;
    end
    case (state_q)
      BUF_EMPTY: begin
        if (wr_valid) begin
          state_d    = BUF_FULL;
          buf_addr_d = wr_addr;
          buf_data_d = wr_data;
        end
      end
      BUF_FULL: begin
        if (!rd_slot) begin
          state_d = BUF_EMPTY;
          if (buf_in_range) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = buf_addr_q;
            mem_wdata = buf_data_q;
          end else begin
            wr_err_d = 1'b1;
          end
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  // Prefetch word pipeline and pixel serialisation
  always_comb begin
    rd_d        = rd_slot;
    next_word_d = rd_q ? mem_rdata : next_word_q;
    cur_word_d  = (phase == 2'd3) ? next_word_q : cur_word_q;
    lane        = cur_word_q[PIX_W-1:0];
    case (phase)
      2'd1:    lane = cur_word_q[2*PIX_W-1:PIX_W];
      2'd2:    lane = cur_word_q[3*PIX_W-1:2*PIX_W];
      2'd3:    lane = cur_word_q[4*PIX_W-1:3*PIX_W];
      default: lane = cur_word_q[PIX_W-1:0];
    endcase
    pixel_d    = video_on ? lane : '0;
    video_on_d = video_on;
    hsync_d    = hsync;
    vsync_d    = vsync;
  end

  // Control and display registers, cleared by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= BUF_EMPTY;
      wr_err_q    <= 1'b0;
      rd_q        <= 1'b0;
      next_word_q <= '0;
      cur_word_q  <= '0;
      pixel_q     <= '0;
      video_on_q  <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_err_q    <= wr_err_d;
      rd_q        <= rd_d;
      next_word_q <= next_word_d;
      cur_word_q  <= cur_word_d;
      pixel_q     <= pixel_d;
      video_on_q  <= video_on_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  // Buffered write payload; only meaningful while the buffer is FULL
  always_ff @(posedge clk) begin
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
  end

  assign wr_ready = (state_q == BUF_EMPTY);
  assign wr_err   = wr_err_q;
  assign pixel    = pixel_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural RAM and a pixel scoreboard.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  x, y;
  logic        video_on, hsync, vsync;
  logic        wr_valid;
  logic        wr_ready;
  logic [16:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_err;
  logic        mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [7:0]  pixel;
  logic        video_on_q, hsync_q, vsync_q;

  vga_fb_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .video_on   (video_on),
    .hsync      (hsync),
    .vsync      (vsync),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pixel      (pixel),
    .video_on_q (video_on_q),
    .hsync_q    (hsync_q),
    .vsync_q    (vsync_q)
  );

  always #5 clk = ~clk;

  // Synchronous-read single-port RAM, one cycle read latency
  logic [31:0] ram [0:76799];
  always @(posedge clk) begin
    if (mem_en && (mem_addr < 17'd76800)) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct {
    logic       v;
    logic       h;
    logic       vs;
    logic       chk;
    logic [7:0] p;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cx, cy;
  bit          chk_pix;
  logic        s_en, s_we;
  logic [16:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] saved;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (x=%0d y=%0d)", tag, obs, exp_v, cx, cy);
    end
  endtask

  task automatic drive_pos();
    x        = 10'(cx);
    y        = 10'(cy);
    video_on = (cx < 640) && (cy < 480);
    hsync    = !((cx >= 656) && (cx < 752));
    vsync    = !((cy >= 490) && (cy < 492));
  endtask

  task automatic advance();
    cx++;
    if (cx == 800) begin
      cx = 0;
      cy = (cy == 524) ? 0 : cy + 1;
    end
  endtask

  // One pixel clock: drive beam, check RAM strobes mid-cycle, check outputs after the edge
  task automatic run_cycle();
    exp_t        e;
    int          g, ph, nln;
    logic        erd;
    logic [16:0] eaddr;
    drive_pos();
    g    = cx / 4;
    ph   = cx % 4;
    e.v  = video_on;
    e.h  = hsync;
    e.vs = vsync;
    e.chk = chk_pix || !video_on;
    e.p  = video_on ? 8'((cy * 160 + g + ph) % 256) : 8'h00;
    sb.push_back(e);
    erd   = 1'b0;
    eaddr = '0;
    if (ph == 0 && (g + 1) < 160 && cy < 480) begin
      erd   = 1'b1;
      eaddr = 17'(cy * 160 + g + 1);
    end
    if (cx == 796) begin
      nln = (cy == 524) ? 0 : cy + 1;
      if (nln < 480) begin
        erd   = 1'b1;
        eaddr = 17'(nln * 160);
      end
    end
    #2;
    s_en    = mem_en;
    s_we    = mem_we;
    s_addr  = mem_addr;
    s_wdata = mem_wdata;
    chk("read_slot", 32'(s_en && !s_we), 32'(erd));
    if (erd) chk("read_addr", 32'(s_addr), 32'(eaddr));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("video_on_q", 32'(video_on_q), 32'(e.v));
    chk("hsync_q", 32'(hsync_q), 32'(e.h));
    chk("vsync_q", 32'(vsync_q), 32'(e.vs));
    if (e.chk) chk("pixel", 32'(pixel), 32'(e.p));
    advance();
  endtask

  task automatic run_to(input int tx, input int ty);
    while (!(cx == tx && cy == ty)) run_cycle();
  endtask

  initial begin
    for (int k = 0; k < 76800; k++)
      ram[k] = {8'((k + 3) % 256), 8'((k + 2) % 256), 8'((k + 1) % 256), 8'(k % 256)};
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    cx = 0; cy = 0; chk_pix = 1'b0;
    drive_pos();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_video_on_q", 32'(video_on_q), 32'd0);
    chk("rst_hsync_q", 32'(hsync_q), 32'd0);
    chk("rst_vsync_q", 32'(vsync_q), 32'd0);
    reset_n = 1'b1;

    // Wrap from the last line: line-start prefetch of word 0
    cx = 780; cy = 524;
    run_to(796, 524);
    run_cycle();
    chk("wrap_read_en", 32'(s_en && !s_we), 32'd1);
    chk("wrap_read_addr", 32'(s_addr), 32'd0);
    run_to(0, 0);
    chk_pix = 1'b1;

    // Write offered just before the line-start slot: stalls through 796, issues at 797
    run_to(795, 0);
    wr_valid = 1'b1; wr_addr = 17'd76000; wr_data = 32'hA5A5_0001;
    run_cycle();
    wr_valid = 1'b0;
    chk("c_ready_after_accept", 32'(wr_ready), 32'd0);
    run_cycle();
    chk("c_no_we_in_slot", 32'(s_we), 32'd0);
    chk("c_ready_stalled", 32'(wr_ready), 32'd0);
    run_cycle();
    chk("c_we_797", 32'(s_en && s_we), 32'd1);
    chk("c_addr_797", 32'(s_addr), 32'd76000);
    chk("c_wdata_797", s_wdata, 32'hA5A5_0001);
    chk("c_ready_after_issue", 32'(wr_ready), 32'd1);
    chk("c_ram_written", ram[76000], 32'hA5A5_0001);

    // Write accepted at x=8 issues at x=9 (phase 1)
    run_to(8, 1);
    wr_valid = 1'b1; wr_addr = 17'd76001; wr_data = 32'h1234_5678;
    run_cycle();
    wr_valid = 1'b0;
    chk("b_ready_low", 32'(wr_ready), 32'd0);
    run_cycle();
    chk("b_we_x9", 32'(s_en && s_we), 32'd1);
    chk("b_addr_x9", 32'(s_addr), 32'd76001);
    chk("b_wdata_x9", s_wdata, 32'h1234_5678);
    chk("b_ready_high", 32'(wr_ready), 32'd1);
    chk("b_ram_written", ram[76001], 32'h1234_5678);

    // Out-of-range write is dropped with a single wr_err pulse
    run_to(21, 1);
    wr_valid = 1'b1; wr_addr = 17'd76800; wr_data = 32'hDEAD_BEEF;
    run_cycle();
    wr_valid = 1'b0;
    chk("d_ready_low", 32'(wr_ready), 32'd0);
    run_cycle();
    chk("d_no_en", 32'(s_en), 32'd0);
    chk("d_no_we", 32'(s_we), 32'd0);
    chk("d_err_pulse", 32'(wr_err), 32'd1);
    chk("d_ready_back", 32'(wr_ready), 32'd1);
    run_cycle();
    chk("d_err_cleared", 32'(wr_err), 32'd0);

    // Finish displaying lines 0 and 1 against the scoreboard
    run_to(0, 2);

    // Last active line: no line-start read for line 480
    chk_pix = 1'b0;
    cx = 790; cy = 479;
    run_to(796, 479);
    run_cycle();
    chk("e_no_read_479", 32'(s_en), 32'd0);
    run_to(10, 480);

    // Reset while a write is buffered mid-line
    cx = 96; cy = 3;
    saved = ram[76100];
    run_to(100, 3);
    wr_valid = 1'b1; wr_addr = 17'd76100; wr_data = 32'hCAFE_F00D;
    run_cycle();
    wr_valid = 1'b0;
    chk("f_full_before_reset", 32'(wr_ready), 32'd0);
    drive_pos();
    #2;
    reset_n = 1'b0;
    #1;
    chk("f_ready_in_reset", 32'(wr_ready), 32'd1);
    chk("f_pixel_in_reset", 32'(pixel), 32'd0);
    chk("f_err_in_reset", 32'(wr_err), 32'd0);
    chk("f_no_we_in_reset", 32'(mem_we), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("f_buffer_discarded", ram[76100], saved);
    reset_n = 1'b1;
    cx = 780; cy = 524;
    run_to(0, 0);
    chk_pix = 1'b1;
    run_to(0, 1);
    chk("f_ready_after", 32'(wr_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
